// File: rtl/exec_mem_arbiter.sv
// Shares one memory port between instruction fetch and execute-stage load/store traffic.
// Define ARB_TIMEOUT_EN to abort a read whose response has not arrived after TIMEOUT cycles.
module exec_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MASK_W       = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              reset,
  // execute stage
  input  logic              ex_write_in,
  input  logic              ex_read_in,
  input  logic [ADDR_W-1:0] ex_addr_in,
  input  logic [DATA_W-1:0] ex_data_in,
  input  logic [MASK_W-1:0] ex_mask_in,
  output logic              ex_busy_out,
  output logic              ex_overflow_out,
  output logic              ex_rvalid_out,
  output logic [DATA_W-1:0] ex_rdata_out,
  // fetch stage
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_gnt_out,
  output logic              if_rvalid_out,
  output logic [DATA_W-1:0] if_rdata_out,
  // memory port
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  output logic [MASK_W-1:0] mem_mask_out,
  input  logic              mem_ready_in,
  input  logic              mem_rvalid_in,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              timeout_out
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT < 1) begin : g_param_check
    $error("exec_mem_arbiter: STARVE_LIMIT must be 1..15 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t r_state;
  state_t w_state_next;

  logic              r_slot_valid;
  logic              r_slot_we;
  logic [ADDR_W-1:0] r_slot_addr;
  logic [DATA_W-1:0] r_slot_data;
  logic [MASK_W-1:0] r_slot_mask;
  logic              r_overflow;
  logic [3:0]        r_starve;

  logic              r_owner_fetch;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [MASK_W-1:0] r_mem_mask;
  logic              r_if_gnt;
  logic              r_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_ex_rvalid;
  logic [DATA_W-1:0] r_ex_rdata;
  logic              r_timeout;

  logic w_ex_pulse;
  logic w_starved;
  logic w_data_grant;
  logic w_fetch_grant;
  logic w_accept;
  logic w_resp;
  logic w_timeout_hit;

  assign w_ex_pulse    = ex_write_in | ex_read_in;
  // Fetch overrides a pending data request only once data has won STARVE_LIMIT times in a row.
  assign w_starved     = (r_starve == STARVE_MAX) && if_req_in;
  assign w_data_grant  = (r_state == IDLE) && r_slot_valid && !w_starved;
  assign w_fetch_grant = (r_state == IDLE) && if_req_in && !w_data_grant;
  assign w_accept      = (r_state == REQ) && mem_ready_in;
  assign w_resp        = (r_state == WAIT_RESP) && mem_rvalid_in;

`ifdef ARB_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  logic [TCNT_W-1:0] r_tcnt;

  assign w_timeout_hit = (r_state == WAIT_RESP) && !mem_rvalid_in &&
                         (r_tcnt == TCNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcnt <= '0;
    end else if (r_state != WAIT_RESP) begin
      r_tcnt <= '0;
    end else if (!w_timeout_hit) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end
`else
  assign w_timeout_hit = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:      if (w_data_grant || w_fetch_grant) w_state_next = REQ;
      REQ:       if (mem_ready_in) w_state_next = r_mem_we ? IDLE : WAIT_RESP;
      WAIT_RESP: if (mem_rvalid_in || w_timeout_hit) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  // A pulse may land on the edge the slot is granted away; otherwise a full slot drops it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot_valid <= 1'b0;
      r_slot_we    <= 1'b0;
      r_slot_addr  <= '0;
      r_slot_data  <= '0;
      r_slot_mask  <= '0;
      r_overflow   <= 1'b0;
    end else if (w_ex_pulse) begin
      if (!r_slot_valid || w_data_grant) begin
        r_slot_valid <= 1'b1;
        r_slot_we    <= ex_write_in;
        r_slot_addr  <= ex_addr_in;
        r_slot_data  <= ex_data_in;
        r_slot_mask  <= ex_mask_in;
      end else begin
        r_overflow   <= 1'b1;
      end
    end else if (w_data_grant) begin
      r_slot_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (w_fetch_grant) begin
      r_starve <= '0;
    end else if (w_data_grant) begin
      if (!if_req_in) begin
        r_starve <= '0;
      end else if (r_starve != STARVE_MAX) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner_fetch <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_mask    <= '0;
      r_if_gnt      <= 1'b0;
      r_if_rvalid   <= 1'b0;
      r_if_rdata    <= '0;
      r_ex_rvalid   <= 1'b0;
      r_ex_rdata    <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_if_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_ex_rvalid <= 1'b0;
      r_timeout   <= w_timeout_hit;

      if (w_data_grant) begin
        r_owner_fetch <= 1'b0;
        r_mem_req     <= 1'b1;
        r_mem_we      <= r_slot_we;
        r_mem_addr    <= r_slot_addr;
        r_mem_wdata   <= r_slot_we ? r_slot_data : '0;
        r_mem_mask    <= r_slot_we ? r_slot_mask : '0;
      end else if (w_fetch_grant) begin
        r_owner_fetch <= 1'b1;
        r_mem_req     <= 1'b1;
        r_mem_we      <= 1'b0;
        r_mem_addr    <= if_addr_in;
        r_mem_wdata   <= '0;
        r_mem_mask    <= '0;
      end else if (w_accept) begin
        r_mem_req     <= 1'b0;
        r_if_gnt      <= r_owner_fetch;
      end

      // A timed-out read still completes toward its owner, with zero data.
      if (w_resp || w_timeout_hit) begin
        if (r_owner_fetch) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= w_resp ? mem_rdata_in : '0;
        end else begin
          r_ex_rvalid <= 1'b1;
          r_ex_rdata  <= w_resp ? mem_rdata_in : '0;
        end
      end
    end
  end

  assign ex_busy_out     = r_slot_valid;
  assign ex_overflow_out = r_overflow;
  assign ex_rvalid_out   = r_ex_rvalid;
  assign ex_rdata_out    = r_ex_rdata;
  assign if_gnt_out      = r_if_gnt;
  assign if_rvalid_out   = r_if_rvalid;
  assign if_rdata_out    = r_if_rdata;
  assign mem_req_out     = r_mem_req;
  assign mem_we_out      = r_mem_we;
  assign mem_addr_out    = r_mem_addr;
  assign mem_wdata_out   = r_mem_wdata;
  assign mem_mask_out    = r_mem_mask;
  assign timeout_out     = r_timeout;

endmodule

// File: tb/tb_exec_mem_arbiter.sv
// Scoreboard bench for exec_mem_arbiter: directed stimulus pushes expected memory requests and
// read returns into queues; a monitor (which also models the memory) pops and compares them.
module tb_exec_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              ex_write_in, ex_read_in;
  logic [ADDR_W-1:0] ex_addr_in;
  logic [DATA_W-1:0] ex_data_in;
  logic [MASK_W-1:0] ex_mask_in;
  logic              ex_busy_out, ex_overflow_out, ex_rvalid_out;
  logic [DATA_W-1:0] ex_rdata_out;
  logic              if_req_in;
  logic [ADDR_W-1:0] if_addr_in;
  logic              if_gnt_out, if_rvalid_out;
  logic [DATA_W-1:0] if_rdata_out;
  logic              mem_req_out, mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_wdata_out;
  logic [MASK_W-1:0] mem_mask_out;
  logic              mem_ready_in, mem_rvalid_in;
  logic [DATA_W-1:0] mem_rdata_in;
  logic              timeout_out;

  exec_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .STARVE_LIMIT(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .ex_write_in(ex_write_in), .ex_read_in(ex_read_in), .ex_addr_in(ex_addr_in),
    .ex_data_in(ex_data_in), .ex_mask_in(ex_mask_in), .ex_busy_out(ex_busy_out),
    .ex_overflow_out(ex_overflow_out), .ex_rvalid_out(ex_rvalid_out), .ex_rdata_out(ex_rdata_out),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_gnt_out(if_gnt_out),
    .if_rvalid_out(if_rvalid_out), .if_rdata_out(if_rdata_out),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_mask_out(mem_mask_out), .mem_ready_in(mem_ready_in),
    .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in), .timeout_out(timeout_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
  } mem_txn_t;

  mem_txn_t          exp_mem[$];
  logic [DATA_W-1:0] exp_if[$];
  logic [DATA_W-1:0] exp_ex[$];

  int checks = 0;
  int errors = 0;

  bit                auto_resp = 1'b1;
  bit                manual_rvalid = 1'b0;
  int                resp_cnt = 0;
  logic [ADDR_W-1:0] resp_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_model(input logic [ADDR_W-1:0] a);
    return (a == 32'h100) ? 32'h13 : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic exp_req(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    mem_txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.mask = m;
    exp_mem.push_back(t);
  endtask

  // Memory model plus scoreboard monitor; samples 1 time unit after the falling edge.
  initial begin
    mem_txn_t e;
    forever begin
      @(negedge clk);
      #1;
      mem_rvalid_in = 1'b0;
      if (!reset) resp_cnt = 0;
      if (resp_cnt != 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_rvalid_in = 1'b1;
          mem_rdata_in  = mem_model(resp_addr);
        end
      end
      if (manual_rvalid) begin
        mem_rvalid_in = 1'b1;
        mem_rdata_in  = 32'hDEAD_0000;
      end
      if (reset) begin
        if (mem_req_out && mem_ready_in) begin
          if (exp_mem.size() == 0) begin
            check("mem_unexpected_req", mem_addr_out, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_mem.pop_front();
            check("mem_we", mem_we_out, e.we);
            check("mem_addr", mem_addr_out, e.addr);
            check("mem_mask", mem_mask_out, e.mask);
            if (e.we) check("mem_wdata", mem_wdata_out, e.wdata);
          end
          if (!mem_we_out && auto_resp) begin
            resp_cnt  = 2;
            resp_addr = mem_addr_out;
          end
        end
        if (if_rvalid_out) begin
          if (exp_if.size() == 0) check("if_unexpected_rvalid", if_rdata_out, 64'hFFFF_FFFF_FFFF_FFFF);
          else check("if_rdata", if_rdata_out, exp_if.pop_front());
        end
        if (ex_rvalid_out) begin
          if (exp_ex.size() == 0) check("ex_unexpected_rvalid", ex_rdata_out, 64'hFFFF_FFFF_FFFF_FFFF);
          else check("ex_rdata", ex_rdata_out, exp_ex.pop_front());
        end
      end
    end
  end

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_mem.size() == 0 && exp_if.size() == 0 && exp_ex.size() == 0 && resp_cnt == 0) break;
      @(negedge clk);
    end
    check({"drain_", tag}, exp_mem.size() + exp_if.size() + exp_ex.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ctrl"}, {mem_req_out, mem_we_out, ex_busy_out, ex_overflow_out, ex_rvalid_out,
                           if_gnt_out, if_rvalid_out, timeout_out}, 0);
    check({tag, "_addr"}, mem_addr_out, 0);
    check({tag, "_data"}, |{mem_wdata_out, mem_mask_out, if_rdata_out, ex_rdata_out}, 0);
  endtask

  task automatic do_fetch(input logic [ADDR_W-1:0] a, input string tag);
    int i;
    if_req_in  = 1'b1;
    if_addr_in = a;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_gnt_out) break;
    end
    check({tag, "_gnt_seen"}, (i < 20), 1);
    if_req_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    ex_write_in = 0; ex_read_in = 0; ex_addr_in = '0; ex_data_in = '0; ex_mask_in = '0;
    if_req_in = 0; if_addr_in = '0;
    mem_ready_in = 1'b1; mem_rvalid_in = 1'b0; mem_rdata_in = '0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    reset = 1'b1;
    @(negedge clk);

    // Fetch only: request -> mem_req next cycle, gnt one cycle after ready.
    exp_req(1'b0, 32'h100, '0, '0);
    exp_if.push_back(32'h13);
    if_req_in = 1'b1; if_addr_in = 32'h100;
    @(negedge clk);
    check("fetch_req_latency", mem_req_out, 1);
    check("fetch_we", mem_we_out, 0);
    @(negedge clk);
    check("fetch_gnt", if_gnt_out, 1);
    if_req_in = 1'b0;
    @(negedge clk);
    check("fetch_gnt_pulse", if_gnt_out, 0);
    drain("fetch");

    // Store: busy next cycle, mem_req two cycles after pulse, held while ready low.
    exp_req(1'b1, 32'h2000, 32'hCAFE_BABE, 8'h0F);
    ex_write_in = 1'b1; ex_addr_in = 32'h2000; ex_data_in = 32'hCAFE_BABE; ex_mask_in = 8'h0F;
    mem_ready_in = 1'b0;
    @(negedge clk);
    ex_write_in = 1'b0;
    check("store_busy", ex_busy_out, 1);
    check("store_req_early", mem_req_out, 0);
    @(negedge clk);
    check("store_req", {mem_req_out, mem_we_out}, 2'b11);
    check("store_addr", mem_addr_out, 32'h2000);
    check("store_wdata", mem_wdata_out, 32'hCAFE_BABE);
    check("store_mask", mem_mask_out, 8'h0F);
    check("store_busy_clear", ex_busy_out, 0);
    @(negedge clk);
    check("store_req_held", {mem_req_out, mem_addr_out}, {1'b1, 32'h2000});
    mem_ready_in = 1'b1;
    @(negedge clk);
    check("store_req_done", mem_req_out, 0);
    drain("store");

    // Starvation: fetch held, 6 back-to-back stores -> D,D,D,D,F,D,D then a final F.
    for (int i = 0; i < 4; i++) exp_req(1'b1, 32'h3000 + 4 * i, 32'h1000_0000 + i, 8'hFF);
    exp_req(1'b0, 32'h100, '0, '0);
    for (int i = 4; i < 6; i++) exp_req(1'b1, 32'h3000 + 4 * i, 32'h1000_0000 + i, 8'hFF);
    exp_req(1'b0, 32'h100, '0, '0);
    exp_if.push_back(32'h13);
    exp_if.push_back(32'h13);
    fork
      begin
        int n = 0;
        for (int cyc = 0; cyc < 200 && n < 6; cyc++) begin
          if (!ex_busy_out) begin
            ex_write_in = 1'b1; ex_addr_in = 32'h3000 + 4 * n;
            ex_data_in = 32'h1000_0000 + n; ex_mask_in = 8'hFF;
            n++;
          end
          @(negedge clk);
          ex_write_in = 1'b0;
        end
        check("starve_pulses", n, 6);
      end
      begin
        int g = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
          @(negedge clk);
          if (ex_busy_out) break;
        end
        if_req_in = 1'b1; if_addr_in = 32'h100;
        for (int cyc = 0; cyc < 400 && g < 2; cyc++) begin
          @(negedge clk);
          if (if_gnt_out) g++;
        end
        if_req_in = 1'b0;
        check("starve_fetch_gnts", g, 2);
      end
    join
    drain("starve");

    // Overflow: capture on the freeing edge is legal; a pulse against a full slot is dropped.
    exp_req(1'b0, 32'h4000, '0, '0);
    exp_req(1'b1, 32'h5000, 32'h55, 8'h03);
    exp_ex.push_back(32'hA5A5_4000);
    ex_read_in = 1'b1; ex_addr_in = 32'h4000; ex_data_in = 32'h77; ex_mask_in = 8'hFF;
    @(negedge clk);
    ex_write_in = 1'b1; ex_read_in = 1'b1; ex_addr_in = 32'h5000;
    ex_data_in = 32'h55; ex_mask_in = 8'h03;
    @(negedge clk);
    check("ovf_legal_capture", ex_overflow_out, 0);
    ex_write_in = 1'b0; ex_read_in = 1'b1; ex_addr_in = 32'h6000;
    @(negedge clk);
    ex_read_in = 1'b0;
    check("ovf_set", ex_overflow_out, 1);
    drain("overflow");
    check("ovf_sticky", ex_overflow_out, 1);

    // Reset during WAIT_RESP; the late response must not surface.
    auto_resp = 1'b0;
    exp_req(1'b0, 32'h200, '0, '0);
    do_fetch(32'h200, "rst_fetch");
    reset = 1'b0;
    #1;
    reset_checks("reset_mid");
    @(negedge clk);
    reset_checks("reset_hold");
    reset = 1'b1;
    manual_rvalid = 1'b1;
    @(negedge clk);
    manual_rvalid = 1'b0;
    begin
      logic seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        seen = seen | if_rvalid_out | ex_rvalid_out;
      end
      check("late_resp_ignored", seen, 0);
    end
    auto_resp = 1'b1;
    exp_req(1'b0, 32'h300, '0, '0);
    exp_if.push_back(32'hA5A5_0300);
    do_fetch(32'h300, "resume");
    drain("resume");

`ifdef ARB_TIMEOUT_EN
    auto_resp = 1'b0;
    exp_req(1'b0, 32'h7000, '0, '0);
    exp_ex.push_back(32'h0);
    ex_read_in = 1'b1; ex_addr_in = 32'h7000;
    @(negedge clk);
    ex_read_in = 1'b0;
    begin
      int hs = -1;
      int to = -1;
      for (int cyc = 0; cyc < 60; cyc++) begin
        if (mem_req_out && mem_ready_in) hs = cyc;
        if (timeout_out) begin
          to = cyc;
          check("timeout_ex_rvalid", ex_rvalid_out, 1);
          break;
        end
        @(negedge clk);
      end
      check("timeout_delay", to - hs, 17);
    end
    auto_resp = 1'b1;
    drain("timeout");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
